// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-master-side signal bundle for apb_req_arbiter.
// master = arbiter view, slave = environment (requesters + APB master) view.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_done;
    logic [DW-1:0]         req_rdata;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic                  transfer;
    logic                  write;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         wdata;
    logic                  ready;
    logic [DW-1:0]         rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, ready, rdata,
        output req_done, req_rdata, grant, busy, transfer, write, addr, wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, ready, rdata,
        input  req_done, req_rdata, grant, busy, transfer, write, addr, wdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_req_arbiter_if.master   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 transfer_q, transfer_d;
    logic                 write_q, write_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [IW-1:0]        win;
    logic                 any;

`ifdef APB_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        any = 1'b0;
        // Descending scan: the last hit is the lowest index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[IW'(i)]) begin
                win = IW'(i);
                any = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] last_q, last_d;

    always_comb begin : rr_pick
        int idx;
        idx = 0;
        win = '0;
        any = 1'b0;
        // Scan offsets from far to near so the nearest one after last_q wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[IW'(idx)]) begin
                win = IW'(idx);
                any = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) last_q <= IW'(NUM_REQ - 1);
        else        last_q <= last_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = done_q;
        transfer_d = 1'b0;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifndef APB_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: if (any) begin
                grant_d    = ONE << win;
                transfer_d = 1'b1;
                write_d    = bus.req_write[win];
                addr_d     = bus.req_addr[win*AW +: AW];
                wdata_d    = bus.req_wdata[win*DW +: DW];
`ifndef APB_ARB_FIXED_PRIO_EN
                last_d     = win;
`endif
                state_d    = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.ready) begin
                rdata_d = bus.rdata;
                done_d  = grant_q;
                state_d = DONE;
            end
            // One dead cycle lets the requester drop valid before IDLE samples it.
            DONE: begin
                done_d  = '0;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            transfer_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            transfer_q <= transfer_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.req_done  = done_q;
    assign bus.req_rdata = rdata_q;
    assign bus.transfer  = transfer_q;
    assign bus.write     = write_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single APB master between `NUM_REQ` independent requesters (CPU load/store unit, DMA, debug port). It sits upstream of the APB master and drives the master's `transfer`/`write`/`addr`/`wdata` command port. It returns `rdata` and a per-requester completion pulse, so exactly one APB transaction is outstanding at any time.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `PCLK`  in  1  system clock; all state updates on the rising edge.
- `PRESET`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester; held until the matching `req_done`.
- `req_write`  in  NUM_REQ  1 = write, 0 = read, per requester.
- `req_addr`  in  NUM_REQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- `req_wdata`  in  NUM_REQ*DW  flattened write data, same packing.
- `req_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `req_rdata`  out  DW  read data; valid while `req_done` is high and held until the next completion.
- `grant`  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- `busy`  out  1  high from ISSUE through DONE.
- `transfer`  out  1  one-cycle start pulse to the APB master.
- `write`, `addr`, `wdata`  out  1/AW/DW  command to the APB master; stable from ISSUE through DONE.
- `ready`  in  1  APB master completion pulse.
- `rdata`  in  DW  APB master read data; valid when `ready` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `req_valid` bit is set, select the winner, register `grant`, `write`, `addr`, `wdata` and set `transfer` = 1, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `transfer` = 0. Go to WAIT.
- WAIT: on `ready` = 1, set `req_rdata` <= `rdata` (also on writes) and `req_done[g]` <= 1, then go to DONE. Otherwise stay in WAIT. There is no timeout.
- DONE: `req_done` <= 0, `grant` <= 0. Go to IDLE.
- Round-robin: pointer `last` holds the index of the previous winner. The search starts at `last+1` and wraps modulo `NUM_REQ`. `last` updates when the grant is made. Reset value of `last` is `NUM_REQ-1`, so requester 0 wins first.
- Requester protocol: hold `valid` and the payload stable until `req_done`. Deassert `valid` no later than the edge after `req_done`. The DONE state guarantees that deasserted `valid` is never sampled as a new request.
- If `req_valid` drops after the grant, the transaction still completes and `req_done` still pulses.
- Payload changes after the grant are ignored because the command was latched in IDLE.
- `ready` seen outside WAIT is ignored.
- `req_valid` rising during ISSUE/WAIT/DONE waits for IDLE, where it is arbitrated against the other pending requests.

## Timing
- Reset values (async, immediate): state IDLE, `transfer` 0, `write` 0, `addr` 0, `wdata` 0, `grant` 0, `busy` 0, `req_done` 0, `req_rdata` 0, `last` = `NUM_REQ-1`.
- Reset asserted mid-transaction aborts it with no `req_done`. The APB master shares `PRESET` and is reset at the same time.
- Edge E0 (IDLE samples `valid`): `transfer` and `grant` are high in cycle E0..E1.
- `transfer` is high for exactly one cycle.
- If `ready` is sampled at edge Ek, `req_done` and `req_rdata` are valid in cycle Ek..Ek+1.
- IDLE at Ek+1. The earliest next `transfer` is at edge Ek+2.
- Arbiter overhead is 3 cycles per transaction on top of the APB master latency.
- Back-to-back requests from two requesters alternate strictly.

## Configuration
- `APB_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `last` is not implemented and `grant` ignores history.
- `APB_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
- Single write: req0 write 0x1000_0000 = 10 -> `transfer` pulses once; `req_done[0]` pulses once; slave0 holds 10.
- Single read: req1 read 0x1000_3000 after a RAM write of 100 -> `req_rdata` = 100 while `req_done[1]` is high.
- Contention: req0 and req1 assert `valid` in the same cycle, and each re-requests immediately after `req_done`, for 4 transactions -> grant order 0,1,0,1. With `APB_ARB_FIXED_PRIO_EN`: 0,0,0,0 while req0 keeps requesting.
- Slow slave: `ready` delayed 5 cycles -> `addr`/`wdata` stay stable through WAIT; no second `transfer`; `req_done` lands 1 cycle after `ready`.
- Drop `valid` mid-transfer: req2 deasserts in WAIT -> the transaction still completes; `req_done[2]` pulses; no retry.
- Reset in WAIT: `PRESET` pulse -> all outputs 0 immediately; no `req_done`; the next request goes to requester 0.
